// File: rtl/sram_port_arbiter.sv
// Three-port fixed-priority arbiter in front of the synchronous external SRAM.
// Port 0 (VGA) always wins; port 2 (loader) gets a forced slot after MAX_WAIT losses to port 1.
module sram_port_arbiter #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_WAIT     = 8
) (
    input  logic        Clock,
    input  logic        Resetn,

    input  logic        req_0,
    input  logic        req_1,
    input  logic        req_2,
    input  logic [17:0] addr_0,
    input  logic [17:0] addr_1,
    input  logic [17:0] addr_2,
    input  logic [15:0] wdata_0,
    input  logic [15:0] wdata_1,
    input  logic [15:0] wdata_2,
    input  logic        we_n_0,
    input  logic        we_n_1,
    input  logic        we_n_2,

    output logic        gnt_0,
    output logic        gnt_1,
    output logic        gnt_2,
    output logic        rvalid_0,
    output logic        rvalid_1,
    output logic        rvalid_2,
    output logic [15:0] rdata,

    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0]  starve_q, starve_d;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_n_q;

    // Stage 0 travels alongside SRAM_address; stage READ_LATENCY meets the returned data.
    logic [READ_LATENCY:0]      vld_q;
    logic [READ_LATENCY:0][1:0] id_q;

    logic        forced;
    logic [2:0]  gnt;
    logic        any_gnt;
    logic [1:0]  sel_id;
    logic [17:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_we_n;

    always_comb begin
        forced = (starve_q == MAX_WAIT_C) && req_2;
        gnt    = '0;
        if (req_0) begin
            gnt[0] = 1'b1;
        end else if (req_1 && !forced) begin
            gnt[1] = 1'b1;
        end else if (req_2) begin
            gnt[2] = 1'b1;
        end
        any_gnt = |gnt;
    end

    always_comb begin
        sel_id    = 2'd0;
        sel_addr  = addr_0;
        sel_wdata = wdata_0;
        sel_we_n  = we_n_0;
        if (gnt[1]) begin
            sel_id    = 2'd1;
            sel_addr  = addr_1;
            sel_wdata = wdata_1;
            sel_we_n  = we_n_1;
        end else if (gnt[2]) begin
            sel_id    = 2'd2;
            sel_addr  = addr_2;
            sel_wdata = wdata_2;
            sel_we_n  = we_n_2;
        end
    end

    // Counter holds while port 0 owns the bus; only port-1 wins count as denials.
    always_comb begin
        starve_d = starve_q;
        if (gnt[2] || !req_2) begin
            starve_d = '0;
        end else if (gnt[1] && (starve_q != MAX_WAIT_C)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_n_q   <= 1'b1;
            vld_q    <= '0;
            id_q     <= '0;
        end else begin
            starve_q <= starve_d;
            if (any_gnt) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                we_n_q  <= sel_we_n;
            end else begin
                we_n_q  <= 1'b1;
            end
            vld_q[0] <= any_gnt && sel_we_n;
            id_q[0]  <= sel_id;
            for (int unsigned s = 1; s <= READ_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                id_q[s]  <= id_q[s-1];
            end
        end
    end

    assign gnt_0 = gnt[0];
    assign gnt_1 = gnt[1];
    assign gnt_2 = gnt[2];

    assign rvalid_0 = vld_q[READ_LATENCY] && (id_q[READ_LATENCY] == 2'd0);
    assign rvalid_1 = vld_q[READ_LATENCY] && (id_q[READ_LATENCY] == 2'd1);
    assign rvalid_2 = vld_q[READ_LATENCY] && (id_q[READ_LATENCY] == 2'd2);
    assign rdata    = SRAM_read_data;

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;

endmodule
